// File: rtl/fifo_sc_fwft_m.sv
// fifo_sc_fwft_m
// Single-clock first-word-fall-through FIFO with arbitrary depth.
// The oldest stored item is always presented on head while empty=0; pop
// acknowledges it and the next item appears right after the clock edge.
//
// Parameters:
//   DATA_ITEM_TYPE  item type, W = $bits(DATA_ITEM_TYPE)
//   DEPTH           storage entries (>= 2, need not be a power of two)
//   AFULL_THRESH    almost_full  when count >= AFULL_THRESH  (1..DEPTH)
//   AEMPTY_THRESH   almost_empty when count <= AEMPTY_THRESH (0..DEPTH-1)
//   RST_BUSY_CYCLES edges rst_busy stays high after reset release (0..255)
//   MEMTYPE         storage style hint: "auto", "lutram" or "registers"
//
// Ports:
//   clk, rst (async, active-high), flush (sync clear of occupancy)
//   tail/push      write side
//   head/pop       read side (head undefined while empty)
//   full, empty, almost_full, almost_empty, count   occupancy status
//   overflow, underflow   one-cycle pulses for rejected push / pop
//   rst_busy       FIFO ignores traffic while high
module fifo_sc_fwft_m #(
    parameter type   DATA_ITEM_TYPE  = logic,
    parameter int    DEPTH           = 32,
    parameter int    AFULL_THRESH    = DEPTH - 2,
    parameter int    AEMPTY_THRESH   = 2,
    parameter int    RST_BUSY_CYCLES = 4,
    parameter string MEMTYPE         = "auto",
    localparam int   CW              = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  DATA_ITEM_TYPE tail,
    input  logic          push,
    output DATA_ITEM_TYPE head,
    input  logic          pop,
    output logic          full,
    output logic          empty,
    output logic          almost_full,
    output logic          almost_empty,
    output logic [CW-1:0] count,
    output logic          overflow,
    output logic          underflow,
    output logic          rst_busy
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    // ------------------------------------------------------------------
    // Elaboration-time parameter checks
    // ------------------------------------------------------------------
    generate
        if (DEPTH < 2) begin : g_bad_depth
            $error("fifo_sc_fwft_m: DEPTH must be >= 2");
        end
        if (AFULL_THRESH < 1 || AFULL_THRESH > DEPTH) begin : g_bad_afull
            $error("fifo_sc_fwft_m: AFULL_THRESH out of range 1..DEPTH");
        end
        if (AEMPTY_THRESH < 0 || AEMPTY_THRESH > DEPTH - 1) begin : g_bad_aempty
            $error("fifo_sc_fwft_m: AEMPTY_THRESH out of range 0..DEPTH-1");
        end
        if (RST_BUSY_CYCLES < 0 || RST_BUSY_CYCLES > 255) begin : g_bad_busy
            $error("fifo_sc_fwft_m: RST_BUSY_CYCLES out of range 0..255");
        end
        if (MEMTYPE != "auto" && MEMTYPE != "lutram" && MEMTYPE != "registers") begin : g_bad_memtype
            $error("fifo_sc_fwft_m: MEMTYPE must be auto, lutram or registers");
        end
    endgenerate

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    DATA_ITEM_TYPE mem [DEPTH];

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [7:0]    busy_q, busy_d;
    logic          overflow_q, overflow_d;
    logic          underflow_q, underflow_d;

    logic acc_push;
    logic acc_pop;

    // Pointers wrap explicitly at DEPTH-1 so any depth works.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // ------------------------------------------------------------------
    // Flag decode: everything derives from registered state only, so
    // there is no combinational path from push/pop to any output.
    // ------------------------------------------------------------------
    assign rst_busy     = (busy_q != 8'd0);
    assign count        = count_q;
    assign full         = (count_q == CW'(DEPTH));
    assign empty        = (count_q == '0);
    assign almost_full  = (count_q >= CW'(AFULL_THRESH));
    assign almost_empty = (count_q <= CW'(AEMPTY_THRESH));
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;
    assign head         = mem[rd_ptr_q];

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        // When full, a push is still taken if a pop frees the slot in the
        // same cycle; the write then lands in the slot being vacated.
        acc_push = push & ~rst_busy & ~flush & (~full | pop);
        acc_pop  = pop & ~rst_busy & ~flush & ~empty;

        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;

        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (acc_push) begin
                wr_ptr_d = ptr_inc(wr_ptr_q);
            end
            if (acc_pop) begin
                rd_ptr_d = ptr_inc(rd_ptr_q);
            end
            case ({acc_push, acc_pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end

        overflow_d  = push & full & ~pop & ~rst_busy & ~flush;
        underflow_d = pop & empty & ~rst_busy & ~flush;

        // Busy window: counts down to zero after reset release, then holds.
        busy_d = (busy_q != 8'd0) ? busy_q - 8'd1 : busy_q;
    end

    // ------------------------------------------------------------------
    // Control registers (asynchronously reset)
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            busy_q      <= 8'(RST_BUSY_CYCLES);
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            busy_q      <= busy_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Storage is never reset; occupancy alone defines valid contents.
    always_ff @(posedge clk) begin
        if (acc_push) begin
            mem[wr_ptr_q] <= tail;
        end
    end

endmodule

// File: doc/fifo_sc_fwft_m.md
# fifo_sc_fwft_m

Parametrised single-clock first-word-fall-through FIFO implemented in plain RTL, with no vendor macro. It is the next generation of the team's single-clock FIFO and keeps the same push/pop/full/empty contract. It adds arbitrary (non-power-of-two) depth, an occupancy count, programmable almost-full/almost-empty thresholds, a synchronous flush, overflow/underflow pulses and a deterministic post-reset busy window. It sits between streaming producers and consumers inside one clock domain.

## Interface
Parameters:
- DATA_ITEM_TYPE, logic: item type; W = $bits(DATA_ITEM_TYPE).
- DEPTH, 32: number of storage entries; any integer ≥ 2.
- AFULL_THRESH, DEPTH-2: almost_full asserts when count ≥ AFULL_THRESH; range 1..DEPTH.
- AEMPTY_THRESH, 2: almost_empty asserts when count ≤ AEMPTY_THRESH; range 0..DEPTH-1.
- RST_BUSY_CYCLES, 4: cycles rst_busy stays high after reset release; range 0..255.
- MEMTYPE, "auto": storage style hint.
  - Allowed values: "auto", "lutram", "registers".
  - Storage is always read combinationally.
  - Any other value is an elaboration error, as are out-of-range parameters.

Ports (CW = $clog2(DEPTH+1)):
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- flush  in  1  synchronous clear of occupancy.
- tail  in  W  write data.
- push  in  1  write request.
- head  out  W  oldest stored item; valid while empty=0.
- pop  in  1  read/acknowledge request.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- almost_full  out  1  count ≥ AFULL_THRESH.
- almost_empty  out  1  count ≤ AEMPTY_THRESH.
- count  out  CW  current occupancy.
- overflow  out  1  one-cycle pulse: a push was rejected because the FIFO was full.
- underflow  out  1  one-cycle pulse: a pop was rejected because the FIFO was empty.
- rst_busy  out  1  FIFO not accepting traffic (replaces wr_rst_busy/rd_rst_busy).

## Operation
State:
- wr_ptr and rd_ptr, each 0..DEPTH-1; each wraps DEPTH-1 → 0 with no power-of-two assumption.
- count register.
- busy counter, 8 bits.
- Storage array of DEPTH×W. Storage is never reset or cleared.

Outputs:
- head = mem[rd_ptr], combinational from registered state.
- All flags are combinational decodes of the registered count; there is no other flag state.

Control:
- acc_push = push & ~rst_busy & ~flush & (~full | pop).
- acc_pop = pop & ~rst_busy & ~flush & ~empty.
- acc_push: write mem[wr_ptr] ← tail, then advance wr_ptr.
- acc_pop: advance rd_ptr.
- count += acc_push − acc_pop.

Simultaneous events:
- Push and pop while full: both are accepted and count stays at DEPTH. The write lands in the slot being vacated; head shows the old item this cycle.
- Push and pop while empty: the push is accepted, the pop is ignored, underflow pulses, and count becomes 1.
- Push and pop otherwise: both are accepted and count is unchanged.

Error pulses:
- overflow = push & full & ~pop & ~rst_busy & ~flush, registered (1 cycle).
- underflow = pop & empty & ~rst_busy & ~flush, registered (1 cycle).

Flush:
- wr_ptr, rd_ptr and count all ← 0.
- Flush has priority over push and pop in the same cycle: both are dropped and no error pulses are generated.

Reset and busy sequencing (states RESET → BUSY → RUN):
- RESET: rst high. Busy counter ← RST_BUSY_CYCLES; pointers and count ← 0.
- BUSY: counter decrements once per cycle while nonzero.
- RUN: counter == 0. rst_busy = (counter ≠ 0).
- With RST_BUSY_CYCLES = 0, rst_busy is 0 even during reset.
- Reset asserted mid-operation discards all contents immediately (asynchronous) and re-enters RESET.

## Timing
- Reset values: count 0, empty 1, full 0, almost_empty 1, almost_full 0, overflow 0, underflow 0, rst_busy 1 (0 if RST_BUSY_CYCLES = 0).
- head is undefined while empty=1. The bench must not check it then.
- After rst falls, rst_busy stays high for exactly RST_BUSY_CYCLES rising edges.
- Push→visible latency: 1 cycle. After push at edge N into an empty FIFO, empty=0 and head=tail right after edge N.
- Pop latency: 1 cycle. After pop at edge N, the next item is on head right after edge N.
- Full on push is reported right after the edge that writes the DEPTH-th item.
- overflow and underflow are high during the cycle following the offending edge, for exactly one cycle.
- No combinational path from push/pop to any output; max throughput is 1 push plus 1 pop per cycle.

## Test plan
- Reset / busy window:
  - Stimulus: DEPTH=5, RST_BUSY_CYCLES=4; rst pulsed, then pushes on every cycle.
  - Required: rst_busy stays high for 4 edges after release; pushes during that window are ignored with no overflow pulse; count stays 0.
- Non-power-of-two wrap:
  - Stimulus: DEPTH=5; push 0x01..0x05; check full=1 and count=5; pop 3; push 0x06..0x08; pop all.
  - Required: output order 01..08; wr_ptr wraps 4→0; empty=1 and count=0 at end.
- Simultaneous events:
  - Stimulus: push+pop while full.
  - Required: count stays 5, head advances, no overflow pulse.
  - Stimulus: push+pop while empty.
  - Required: count becomes 1, underflow pulses once, head = pushed value.
- Threshold flags:
  - Stimulus: DEPTH=8, AFULL_THRESH=6, AEMPTY_THRESH=2; fill 0→8, then drain 8→0.
  - Required: almost_full is high exactly at counts 6–8; almost_empty is high exactly at counts 0–2.
- Error pulses and flush:
  - Stimulus: push when full (no pop).
  - Required: 1-cycle overflow pulse, contents unchanged.
  - Stimulus: pop when empty.
  - Required: 1-cycle underflow pulse.
  - Stimulus: flush together with push at count 3.
  - Required: count becomes 0, empty=1, the push is dropped, no error pulse.
- Mid-operation reset:
  - Stimulus: assert rst asynchronously at count 4, between clock edges.
  - Required: count=0 and empty=1 immediately, rst_busy=1; after the busy window, normal operation resumes with the first push appearing on head.
